// File: rtl/score_display_ctrl.sv
// Pong score controller and 7-segment display sequencer.
// Ports: clk_200hz/reset, point_p1/p2 and new_game levels in; BCD digits, blank mask, game_over, winner out.
module score_display_ctrl #(
  parameter int WIN_SCORE   = 11,
  parameter int FLASH_TICKS = 200,
  parameter int BLINK_HALF  = 50
) (
  input  logic       clk_200hz,
  input  logic       reset,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       new_game,
  output logic [3:0] player1_unit,
  output logic [3:0] player1_tens,
  output logic [3:0] player2_unit,
  output logic [3:0] player2_tens,
  output logic [3:0] blank,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [1:0] S_PLAY  = 2'd0;
  localparam logic [1:0] S_FLASH = 2'd1;
  localparam logic [1:0] S_WIN   = 2'd2;

  localparam int TW = $clog2(FLASH_TICKS + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [7:0] WIN_BCD =
    {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  logic [1:0]    r_state, n_state;
  logic [7:0]    r_p1, n_p1;
  logic [7:0]    r_p2, n_p2;
  logic [1:0]    r_pend, n_pend;
  logic [1:0]    r_mask, n_mask;
  logic [1:0]    r_winner, n_winner;
  logic [TW-1:0] r_timer, n_timer;
  logic [BW-1:0] r_pcnt, n_pcnt;
  logic          r_phase, n_phase;
  logic          r_prev1, r_prev2, r_prevng;
  logic [3:0]    r_blank;
  logic          r_game_over;

  logic [1:0] w_pt;
  logic       w_ng;
  logic [1:0] w_inc;
  logic       w_sel1, w_sel2;
  logic [3:0] w_blank;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign w_pt = {point_p2 & ~r_prev2, point_p1 & ~r_prev1};
  assign w_ng = new_game & ~r_prevng;

  always_comb begin
    n_state  = r_state;
    n_p1     = r_p1;
    n_p2     = r_p2;
    n_pend   = r_pend;
    n_mask   = r_mask;
    n_winner = r_winner;
    n_timer  = r_timer;
    n_pcnt   = r_pcnt;
    n_phase  = r_phase;
    w_inc    = 2'b00;
    if (r_state != S_PLAY) begin
      if (r_pcnt == BW'(BLINK_HALF - 1)) begin
        n_pcnt  = '0;
        n_phase = ~r_phase;
      end else begin
        n_pcnt = r_pcnt + 1'b1;
      end
    end
    if (w_ng) begin
      n_state  = S_PLAY;
      n_p1     = '0;
      n_p2     = '0;
      n_pend   = '0;
      n_mask   = '0;
      n_winner = '0;
      n_timer  = '0;
      n_pcnt   = '0;
      n_phase  = 1'b0;
    end else begin
      unique case (r_state)
        S_PLAY: w_inc = w_pt;
        S_FLASH: begin
          if (r_timer == TW'(FLASH_TICKS - 1)) begin
            // an edge on the exit cycle is kept, not lost
            w_inc   = r_pend | w_pt;
            n_pend  = '0;
            n_timer = '0;
            n_state = S_PLAY;
          end else begin
            n_timer = r_timer + 1'b1;
            n_pend  = r_pend | w_pt;
          end
        end
        S_WIN: ;
        default: n_state = S_PLAY;
      endcase
    end
    if (|w_inc) begin
      if (w_inc[0] && r_p1 != WIN_BCD) n_p1 = bcd_inc(r_p1);
      if (w_inc[1] && r_p2 != WIN_BCD) n_p2 = bcd_inc(r_p2);
      n_pend  = '0;
      n_timer = '0;
      n_pcnt  = '0;
      n_phase = 1'b0;
      if (n_p1 == WIN_BCD || n_p2 == WIN_BCD) begin
        n_state  = S_WIN;
        n_winner = {n_p2 == WIN_BCD, n_p1 == WIN_BCD};
        n_mask   = '0;
      end else begin
        n_state = S_FLASH;
        n_mask  = w_inc;
      end
    end
  end

  // blank is registered from next-state values so it stays aligned with the digits
  always_comb begin
    w_sel1 = (n_state == S_FLASH && n_mask[0]) ||
             (n_state == S_WIN && n_winner[0]);
    w_sel2 = (n_state == S_FLASH && n_mask[1]) ||
             (n_state == S_WIN && n_winner[1]);
    w_blank[0] = n_phase & w_sel1;
    w_blank[1] = (n_p1[7:4] == 4'd0) | (n_phase & w_sel1);
    w_blank[2] = n_phase & w_sel2;
    w_blank[3] = (n_p2[7:4] == 4'd0) | (n_phase & w_sel2);
  end

  always_ff @(posedge clk_200hz or posedge reset) begin
    if (reset) begin
      r_state     <= S_PLAY;
      r_p1        <= '0;
      r_p2        <= '0;
      r_pend      <= '0;
      r_mask      <= '0;
      r_winner    <= '0;
      r_timer     <= '0;
      r_pcnt      <= '0;
      r_phase     <= 1'b0;
      r_prev1     <= 1'b0;
      r_prev2     <= 1'b0;
      r_prevng    <= 1'b0;
      r_blank     <= 4'b1010;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= n_state;
      r_p1        <= n_p1;
      r_p2        <= n_p2;
      r_pend      <= n_pend;
      r_mask      <= n_mask;
      r_winner    <= n_winner;
      r_timer     <= n_timer;
      r_pcnt      <= n_pcnt;
      r_phase     <= n_phase;
      r_prev1     <= point_p1;
      r_prev2     <= point_p2;
      r_prevng    <= new_game;
      r_blank     <= w_blank;
      r_game_over <= (n_state == S_WIN);
    end
  end

  assign player1_tens = r_p1[7:4];
  assign player1_unit = r_p1[3:0];
  assign player2_tens = r_p2[7:4];
  assign player2_unit = r_p2[3:0];
  assign blank        = r_blank;
  assign game_over    = r_game_over;
  assign winner       = r_winner;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed table-driven bench for score_display_ctrl.
// Rows pulse inputs for one cycle, run idle cycles, then compare all outputs.
module tb_score_display_ctrl;

  logic       clk_200hz = 1'b0;
  logic       reset;
  logic       point_p1, point_p2, new_game;
  logic [3:0] player1_unit, player1_tens;
  logic [3:0] player2_unit, player2_tens;
  logic [3:0] blank;
  logic       game_over;
  logic [1:0] winner;

  int n_cmp = 0;
  int n_bad = 0;

  score_display_ctrl dut (
    .clk_200hz    (clk_200hz),
    .reset        (reset),
    .point_p1     (point_p1),
    .point_p2     (point_p2),
    .new_game     (new_game),
    .player1_unit (player1_unit),
    .player1_tens (player1_tens),
    .player2_unit (player2_unit),
    .player2_tens (player2_tens),
    .blank        (blank),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clk_200hz = ~clk_200hz;

  typedef struct {
    logic       p1;
    logic       p2;
    logic       ng;
    int         cyc;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [3:0] eb;
    logic       eg;
    logic [1:0] ew;
    string      nm;
  } row_t;

  row_t ta[$];
  row_t tb[$];

  function automatic row_t mk(
    input logic p1, input logic p2, input logic ng,
    input int cyc, input logic [7:0] e1, input logic [7:0] e2,
    input logic [3:0] eb, input logic eg, input logic [1:0] ew,
    input string nm);
    row_t r;
    r.p1 = p1; r.p2 = p2; r.ng = ng; r.cyc = cyc;
    r.e1 = e1; r.e2 = e2; r.eb = eb; r.eg = eg; r.ew = ew;
    r.nm = nm;
    return r;
  endfunction

  function automatic logic [22:0] act();
    return {player1_tens, player1_unit, player2_tens,
            player2_unit, blank, game_over, winner};
  endfunction

  task automatic check(input string nm, input logic [22:0] exp);
    logic [22:0] a;
    a = act();
    n_cmp++;
    if (a !== exp) begin
      n_bad++;
      $display("FAIL %s: got p1=%h p2=%h blank=%b go=%b win=%b, want p1=%h p2=%h blank=%b go=%b win=%b",
        nm, a[22:15], a[14:7], a[6:3], a[2], a[1:0],
        exp[22:15], exp[14:7], exp[6:3], exp[2], exp[1:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk_200hz);
    #1;
  endtask

  task automatic run_row(input row_t r);
    point_p1 = r.p1;
    point_p2 = r.p2;
    new_game = r.ng;
    tick();
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    new_game = 1'b0;
    repeat (r.cyc - 1) tick();
    check(r.nm, {r.e1, r.e2, r.eb, r.eg, r.ew});
  endtask

  localparam logic [22:0] RST_EXP = {8'h00, 8'h00, 4'b1010, 1'b0, 2'b00};

  initial begin
    reset    = 1'b1;
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    new_game = 1'b0;

    // single p1 point: flash on blank[0] every 50 cycles
    ta.push_back(mk(1,0,0,  1, 8'h01,8'h00,4'b1010,0,2'b00,"t1_e0"));
    ta.push_back(mk(0,0,0, 49, 8'h01,8'h00,4'b1010,0,2'b00,"t1_e49"));
    ta.push_back(mk(0,0,0,  1, 8'h01,8'h00,4'b1011,0,2'b00,"t1_e50"));
    ta.push_back(mk(0,0,0, 50, 8'h01,8'h00,4'b1010,0,2'b00,"t1_e100"));
    ta.push_back(mk(0,0,0, 50, 8'h01,8'h00,4'b1011,0,2'b00,"t1_e150"));
    ta.push_back(mk(0,0,0, 49, 8'h01,8'h00,4'b1011,0,2'b00,"t1_e199"));
    ta.push_back(mk(0,0,0,  1, 8'h01,8'h00,4'b1010,0,2'b00,"t1_play"));
    // climb to 9, then the carry to 10
    for (int i = 2; i <= 9; i++)
      ta.push_back(mk(1,0,0,201, 8'(i),8'h00,4'b1010,0,2'b00,
                      $sformatf("t2_p1_%0d", i)));
    ta.push_back(mk(1,0,0,  1, 8'h10,8'h00,4'b1000,0,2'b00,"t2_carry"));
    ta.push_back(mk(0,0,0,199, 8'h10,8'h00,4'b1011,0,2'b00,"t2_e199"));
    ta.push_back(mk(0,0,0,  1, 8'h10,8'h00,4'b1000,0,2'b00,"t2_play"));
    // win, ignored points, new game
    ta.push_back(mk(1,0,0,  1, 8'h11,8'h00,4'b1000,1,2'b01,"t5_win"));
    ta.push_back(mk(0,0,0, 50, 8'h11,8'h00,4'b1011,1,2'b01,"t5_blink"));
    ta.push_back(mk(1,0,0,  1, 8'h11,8'h00,4'b1011,1,2'b01,"t5_ign_p1"));
    ta.push_back(mk(0,1,0,  1, 8'h11,8'h00,4'b1011,1,2'b01,"t5_ign_p2"));
    ta.push_back(mk(0,0,1,  1, 8'h00,8'h00,4'b1010,0,2'b00,"t5_newgame"));
    // simultaneous points
    for (int i = 1; i <= 5; i++)
      ta.push_back(mk(1,1,0,201, 8'(i),8'(i),4'b1010,0,2'b00,
                      $sformatf("t3_both_%0d", i)));
    ta.push_back(mk(1,1,0,  1, 8'h06,8'h06,4'b1010,0,2'b00,"t3_66"));
    ta.push_back(mk(0,0,0, 50, 8'h06,8'h06,4'b1111,0,2'b00,"t3_mask"));
    ta.push_back(mk(0,0,0,150, 8'h06,8'h06,4'b1010,0,2'b00,"t3_play"));
    // one-deep pending
    ta.push_back(mk(0,1,0,  1, 8'h06,8'h07,4'b1010,0,2'b00,"t4_e0"));
    ta.push_back(mk(0,0,0,  9, 8'h06,8'h07,4'b1010,0,2'b00,"t4_e9"));
    ta.push_back(mk(0,1,0,  1, 8'h06,8'h07,4'b1010,0,2'b00,"t4_pend"));
    ta.push_back(mk(0,0,0,  5, 8'h06,8'h07,4'b1010,0,2'b00,"t4_e15"));
    ta.push_back(mk(0,1,0,  1, 8'h06,8'h07,4'b1010,0,2'b00,"t4_drop"));
    ta.push_back(mk(0,0,0,183, 8'h06,8'h07,4'b1110,0,2'b00,"t4_e199"));
    ta.push_back(mk(0,0,0,  1, 8'h06,8'h08,4'b1010,0,2'b00,"t4_apply"));
    ta.push_back(mk(0,0,0,199, 8'h06,8'h08,4'b1110,0,2'b00,"t4_re199"));
    ta.push_back(mk(0,0,0,  1, 8'h06,8'h08,4'b1010,0,2'b00,"t4_once"));
    // set a pending point mid-flash before the reset
    ta.push_back(mk(1,0,0,  1, 8'h07,8'h08,4'b1010,0,2'b00,"t6_e0"));
    ta.push_back(mk(0,0,0, 60, 8'h07,8'h08,4'b1011,0,2'b00,"t6_e60"));
    ta.push_back(mk(1,0,0,  1, 8'h07,8'h08,4'b1011,0,2'b00,"t6_pend"));

    tb.push_back(mk(0,0,0,250, 8'h00,8'h00,4'b1010,0,2'b00,"t6_nopend"));
    tb.push_back(mk(1,0,0,  2, 8'h01,8'h00,4'b1010,0,2'b00,"ng_pre"));
    tb.push_back(mk(1,0,1,  1, 8'h00,8'h00,4'b1010,0,2'b00,"ng_prio"));
    tb.push_back(mk(0,1,0,  2, 8'h00,8'h01,4'b1010,0,2'b00,"ng_after"));

    #12;
    check("reset_state", RST_EXP);
    @(negedge clk_200hz);
    reset = 1'b0;

    foreach (ta[i]) run_row(ta[i]);

    reset = 1'b1;
    #1;
    check("async_reset", RST_EXP);
    tick();
    check("reset_hold", RST_EXP);
    reset = 1'b0;

    foreach (tb[i]) run_row(tb[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
